// File: rtl/gpio_mulcnt_pkg.sv
// Shared types and constants for the gpio_mulcnt multiply-and-popcount peripheral.
// Latency: none, declarations only.
// Backpressure: not applicable.
package gpio_mulcnt_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Register offsets from the window base
    localparam logic [15:0] OFF_A1   = 16'h0000;
    localparam logic [15:0] OFF_A2   = 16'h0008;
    localparam logic [15:0] OFF_W    = 16'h0010;
    localparam logic [15:0] OFF_L    = 16'h0018;
    localparam logic [15:0] OFF_CTRL = 16'h0020;

    // Bit positions inside the STATUS read word
    localparam int ST_VALID = 0;
    localparam int ST_READY = 1;
    localparam int ST_ERR   = 2;

    typedef struct packed {
        logic err;
        logic ready;
        logic valid;
    } status_t;

    // Place the status flags at their read-word bit positions, rest zero.
    function automatic logic [31:0] status_word(input status_t s);
        logic [31:0] w;
        w           = '0;
        w[ST_VALID] = s.valid;
        w[ST_READY] = s.ready;
        w[ST_ERR]   = s.err;
        return w;
    endfunction

endpackage

// File: rtl/gpio_mulcnt_if.sv
// Slave register bus between the emulator host and the gpio_mulcnt peripheral.
// Latency: read data is registered one edge after the read strobe is sampled.
// Backpressure: none; every strobe is accepted in the cycle it is sampled.
interface gpio_mulcnt_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (
        output saddress,
        output srd,
        output swr,
        output sdata_in,
        input  sdata_out
    );

    modport slave (
        input  saddress,
        input  srd,
        input  swr,
        input  sdata_in,
        output sdata_out
    );
endinterface

// File: rtl/gpio_mulcnt_mul_seq_core.sv
// Iterative shift-add multiplier: one multiplier bit consumed per step.
// Latency: product valid after OP_W step cycles following load.
// Backpressure: none; the controller decides when to load and step.
module mul_seq_core #(
    parameter int OP_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] product
);
    localparam int PW = 2 * OP_W;

    logic [PW-1:0]   mcand;
    logic [OP_W-1:0] mplier;
    logic [PW-1:0]   acc;

    // Load snapshots the operands; each step adds the shifted multiplicand when the low multiplier bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = acc;

endmodule

// File: rtl/gpio_mulcnt.sv
// Bus-mapped multiply-and-popcount peripheral with completion counter and done interrupt.
// Latency: start at edge k, results and ready at edge k+OP_W+2; reads return one edge after srd.
// Backpressure: none; a start while busy is dropped and flagged in the sticky err bit.
module gpio_mulcnt
    import gpio_mulcnt_pkg::*;
#(
    parameter int          OP_W      = 24,
    parameter int          RES_W     = 32,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0380
) (
    input  logic           clk,
    input  logic           reset,
    gpio_mulcnt_if.slave   bus,
    output logic [31:0]    gpio_out,
    output logic           irq
);
    localparam int PW    = 2 * OP_W;
    localparam int EXT_W = (PW > RES_W) ? PW : RES_W;
    localparam int L_W   = $clog2(RES_W + 1);
    localparam int BC_W  = $clog2(OP_W) + 1;

    localparam logic [15:0] ADDR_A1   = BASE_ADDR + OFF_A1;
    localparam logic [15:0] ADDR_A2   = BASE_ADDR + OFF_A2;
    localparam logic [15:0] ADDR_W    = BASE_ADDR + OFF_W;
    localparam logic [15:0] ADDR_L    = BASE_ADDR + OFF_L;
    localparam logic [15:0] ADDR_CTRL = BASE_ADDR + OFF_CTRL;

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   a1_q;
    logic [OP_W-1:0]   a2_q;
    logic [RES_W-1:0]  w_q;
    logic [L_W-1:0]    l_q;
    logic              res_ok_q;
    status_t           status_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BC_W-1:0]   bit_cnt;

    logic              hit_a1, hit_a2, hit_w, hit_l, hit_ctrl;
    logic              start_wr, start_rej, last_step;
    logic              core_load, core_step, count_en, done_en;
    logic [PW-1:0]     product;
    logic [EXT_W-1:0]  prod_ext;
    logic [RES_W-1:0]  w_next;
    logic              hi_nz;
    logic [L_W-1:0]    ones;
    logic [31:0]       rd_dat;
    logic              unused_wdat;

    // Only the low OP_W write-data bits land in the operand registers.
    assign unused_wdat = ^bus.sdata_in;

    assign hit_a1   = (bus.saddress == ADDR_A1);
    assign hit_a2   = (bus.saddress == ADDR_A2);
    assign hit_w    = (bus.saddress == ADDR_W);
    assign hit_l    = (bus.saddress == ADDR_L);
    assign hit_ctrl = (bus.saddress == ADDR_CTRL);

    assign start_wr  = bus.swr && hit_ctrl;
    assign start_rej = start_wr && (state_q != S_IDLE);
    assign last_step = (bit_cnt == BC_W'(OP_W - 1));

    mul_seq_core #(
        .OP_W (OP_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (core_load),
        .step    (core_step),
        .a       (a1_q),
        .b       (a2_q),
        .product (product)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> MULT for OP_W cycles -> COUNT -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_wr)  state_d = S_MULT;
            S_MULT:  if (last_step) state_d = S_COUNT;
            S_COUNT: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded controls; irq is high for exactly the DONE cycle
    always_comb begin
        core_load = 1'b0;
        core_step = 1'b0;
        count_en  = 1'b0;
        done_en   = 1'b0;
        irq       = 1'b0;
        case (state_q)
            S_IDLE:  core_load = start_wr;
            S_MULT:  core_step = 1'b1;
            S_COUNT: count_en  = 1'b1;
            S_DONE:  begin
                done_en = 1'b1;
                irq     = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiply step counter, restarted on every accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (core_load) begin
            bit_cnt <= '0;
        end else if (core_step) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Operand registers stay writable while busy; the core holds its own snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1_q <= '0;
            a2_q <= '0;
        end else if (bus.swr) begin
            if (hit_a1) a1_q <= bus.sdata_in[OP_W-1:0];
            if (hit_a2) a2_q <= bus.sdata_in[OP_W-1:0];
        end
    end

    // Zero-extend the product so truncation and overflow work for any RES_W/OP_W mix.
    assign prod_ext = EXT_W'(product);
    assign w_next   = prod_ext[RES_W-1:0];
    assign hi_nz    = |(prod_ext >> RES_W);

    // Ones count of the truncated result
    always_comb begin
        ones = '0;
        for (int i = 0; i < RES_W; i++) begin
            ones = ones + L_W'(w_next[i]);
        end
    end

    // Result capture in COUNT; overflow verdict is held until DONE publishes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q      <= '0;
            l_q      <= '0;
            res_ok_q <= 1'b1;
        end else if (count_en) begin
            w_q      <= w_next;
            l_q      <= ones;
            res_ok_q <= ~hi_nz;
        end
    end

    // Status flags: start clears, busy-start sets sticky err, DONE raises ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '{err: 1'b0, ready: 1'b1, valid: 1'b1};
        end else if (core_load) begin
            status_q <= '{err: 1'b0, ready: 1'b0, valid: 1'b1};
        end else begin
            if (start_rej) begin
                status_q.err <= 1'b1;
            end
            if (done_en) begin
                status_q.ready <= 1'b1;
                status_q.valid <= res_ok_q;
            end
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (done_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign gpio_out = 32'(cnt_q);

    // Read mux; W and L are masked until the current operation has completed.
    always_comb begin
        rd_dat = '0;
        if (hit_a1) begin
            rd_dat = 32'(a1_q);
        end else if (hit_a2) begin
            rd_dat = 32'(a2_q);
        end else if (hit_w) begin
            if (status_q.ready) rd_dat = 32'(w_q);
        end else if (hit_l) begin
            if (status_q.ready) rd_dat = 32'(l_q);
        end else if (hit_ctrl) begin
            rd_dat = status_word(status_q);
        end
    end

    // Read data register: loads only on a sampled srd, so a same-cycle write is seen next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sdata_out <= '0;
        end else if (bus.srd) begin
            bus.sdata_out <= rd_dat;
        end
    end

endmodule

// File: tb/tb_gpio_mulcnt.sv
// Directed bench for gpio_mulcnt: default instance plus a CNT_W=4 twin fed the same bus traffic.
// Read expectations go through a scoreboard queue and are popped when sdata_out is valid.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_gpio_mulcnt;
    import gpio_mulcnt_pkg::*;

    localparam int          OP_W = 24;
    localparam logic [15:0] BASE = 16'h0380;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio0, gpio4;
    logic        irq0, irq4;
    int          checks    = 0;
    int          failures  = 0;
    int          irq_cnt   = 0;
    int          irq4_cnt  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    gpio_mulcnt_if bus0 ();
    gpio_mulcnt_if bus4 ();

    assign bus4.saddress = bus0.saddress;
    assign bus4.srd      = bus0.srd;
    assign bus4.swr      = bus0.swr;
    assign bus4.sdata_in = bus0.sdata_in;

    gpio_mulcnt #(
        .OP_W      (OP_W),
        .RES_W     (32),
        .CNT_W     (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0),
        .gpio_out (gpio0),
        .irq      (irq0)
    );

    gpio_mulcnt #(
        .OP_W      (OP_W),
        .RES_W     (32),
        .CNT_W     (4),
        .BASE_ADDR (BASE)
    ) dut4 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus4),
        .gpio_out (gpio4),
        .irq      (irq4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq0) irq_cnt++;
        if (irq4) irq4_cnt++;
    end

    // Reference model: full-width product, truncated result, ones count, status word
    function automatic logic [63:0] mdl_prod(input logic [23:0] a, input logic [23:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic logic [31:0] mdl_w(input logic [23:0] a, input logic [23:0] b);
        logic [63:0] p;
        p = mdl_prod(a, b);
        return p[31:0];
    endfunction

    function automatic logic [31:0] mdl_l(input logic [23:0] a, input logic [23:0] b);
        logic [63:0] p;
        p = mdl_prod(a, b);
        return 32'($countones(p[31:0]));
    endfunction

    function automatic logic [31:0] mdl_st(input logic [23:0] a, input logic [23:0] b, input logic err);
        logic [63:0] p;
        p = mdl_prod(a, b);
        return {29'b0, err, 1'b1, (p[63:32] == 32'h0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] off, input logic [31:0] dat);
        bus0.saddress = BASE + off;
        bus0.sdata_in = dat;
        bus0.swr      = 1'b1;
        @(negedge clk);
        bus0.swr      = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] off, input logic [31:0] exp, input string tag);
        bus0.saddress = BASE + off;
        bus0.srd      = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus0.srd      = 1'b0;
        check(tag_q.pop_front(), bus0.sdata_out, exp_q.pop_front());
    endtask

    // Read and write the same address in one cycle
    task automatic bus_rw(input logic [15:0] off, input logic [31:0] dat, input logic [31:0] exp,
                          input string tag);
        bus0.saddress = BASE + off;
        bus0.sdata_in = dat;
        bus0.swr      = 1'b1;
        bus0.srd      = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus0.swr      = 1'b0;
        bus0.srd      = 1'b0;
        check(tag_q.pop_front(), bus0.sdata_out, exp_q.pop_front());
    endtask

    initial begin
        reset         = 1'b1;
        bus0.saddress = '0;
        bus0.srd      = 1'b0;
        bus0.swr      = 1'b0;
        bus0.sdata_in = '0;
        idle(2);
        check("rst_sdata_out", bus0.sdata_out, 32'h0);
        check("rst_gpio", gpio0, 32'h0);
        check("rst_irq", 32'(irq0), 32'h0);
        reset = 1'b0;
        idle(1);
        bus_read(OFF_CTRL, 32'h3, "rst_status");
        bus_read(OFF_A1, 32'h0, "rst_a1");
        bus_read(OFF_A2, 32'h0, "rst_a2");
        bus_read(OFF_W, 32'h0, "rst_w");
        bus_read(OFF_L, 32'h0, "rst_l");

        // 3 x 5, including the exact ready boundary
        bus_write(OFF_A1, 32'h3);
        bus_write(OFF_A2, 32'h5);
        bus_write(OFF_CTRL, 32'h0);
        idle(OP_W + 1);
        bus_read(OFF_CTRL, 32'h1, "s1_status_k_plus_opw_plus_2");
        bus_read(OFF_CTRL, 32'h3, "s1_status");
        bus_read(OFF_W, 32'h0000000F, "s1_w");
        bus_read(OFF_L, 32'h4, "s1_l");
        check("s1_gpio", gpio0, 32'd1);
        check("s1_irq_count", 32'(irq_cnt), 32'd1);

        // Overflowing operands
        bus_write(OFF_A1, 32'h00FFFFFF);
        bus_write(OFF_A2, 32'h00FFFFFF);
        bus_write(OFF_CTRL, 32'h1);
        idle(OP_W + 2);
        bus_read(OFF_CTRL, 32'h2, "s2_status");
        bus_read(OFF_W, 32'hFE000001, "s2_w");
        bus_read(OFF_L, 32'd8, "s2_l");
        check("s2_gpio", gpio0, 32'd2);

        // Busy start at cycle 5 is rejected; operand write mid-op only affects the register
        bus_write(OFF_A1, 32'h7);
        bus_write(OFF_A2, 32'h9);
        bus_write(OFF_CTRL, 32'h0);
        idle(4);
        bus_write(OFF_CTRL, 32'h0);
        bus_write(OFF_A1, 32'h100);
        idle(OP_W - 4);
        bus_read(OFF_CTRL, mdl_st(24'h7, 24'h9, 1'b1), "s3_status_err");
        bus_read(OFF_W, mdl_w(24'h7, 24'h9), "s3_w");
        bus_read(OFF_L, mdl_l(24'h7, 24'h9), "s3_l");
        bus_read(OFF_A1, 32'h100, "s3_a1");
        check("s3_gpio", gpio0, 32'd3);
        check("s3_irq_count", 32'(irq_cnt), 32'd3);

        // Masked W while busy, unmapped read, write to read-only W
        bus_write(OFF_CTRL, 32'h0);
        idle(2);
        bus_read(OFF_W, 32'h0, "s4_w_busy");
        bus_read(16'h0040, 32'h0, "s4_unmapped");
        bus_write(OFF_W, 32'hDEADBEEF);
        bus_read(OFF_CTRL, 32'h1, "s4_status_busy");
        idle(OP_W - 4);
        bus_read(OFF_W, mdl_w(24'h100, 24'h9), "s4_w");
        bus_read(OFF_L, mdl_l(24'h100, 24'h9), "s4_l");
        bus_read(OFF_CTRL, mdl_st(24'h100, 24'h9, 1'b0), "s4_status");
        check("s4_gpio", gpio0, 32'd4);

        // Same-cycle read/write returns the old value; sdata_out holds without srd
        bus_rw(OFF_A1, 32'h55, 32'h100, "rw_pre_write");
        bus_read(OFF_A1, 32'h55, "rw_post_write");
        bus_write(OFF_A2, 32'h1234);
        idle(3);
        check("sdata_out_hold", bus0.sdata_out, 32'h55);

        // Reset in the middle of an operation
        bus_write(OFF_A1, 32'h3);
        bus_write(OFF_A2, 32'h5);
        bus_write(OFF_CTRL, 32'h0);
        idle(9);
        reset = 1'b1;
        #1;
        check("mid_rst_sdata_out", bus0.sdata_out, 32'h0);
        check("mid_rst_gpio", gpio0, 32'h0);
        check("mid_rst_irq", 32'(irq0), 32'h0);
        check("mid_rst_gpio4", gpio4, 32'h0);
        check("mid_rst_sdata_out4", bus4.sdata_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(OP_W + 5);
        check("mid_rst_no_irq", 32'(irq_cnt), 32'd4);
        bus_read(OFF_CTRL, 32'h3, "mid_rst_status");
        bus_read(OFF_A1, 32'h0, "mid_rst_a1");
        bus_read(OFF_W, 32'h0, "mid_rst_w");
        check("mid_rst_gpio_after", gpio0, 32'h0);

        // Back-to-back operations: 4-bit counter wraps after 15
        for (int i = 1; i <= 16; i++) begin
            bus_write(OFF_CTRL, 32'h0);
            idle(OP_W + 2);
            check($sformatf("cnt4_op%0d", i), gpio4, 32'(i % 16));
            check($sformatf("cnt16_op%0d", i), gpio0, 32'(i));
        end
        bus_read(OFF_CTRL, 32'h3, "b2b_status");
        check("b2b_irq_count", 32'(irq_cnt), 32'd20);
        check("twin_irq_count", 32'(irq4_cnt), 32'(irq_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_mulcnt.md
# gpio_mulcnt

Parametrised bus-mapped multiply-and-popcount peripheral for the GPIO emulator slave bus. The host writes two operands, then writes a start command. The block runs an iterative shift-add multiply and counts the ones in the result. It then exposes result, ones-count and status registers, and drives a completed-operation counter on `gpio_out`. This is the next generation of the emulator arithmetic peripheral: fully synchronous bus sampling, configurable widths and base address, overflow reporting, busy-reject and a done interrupt.

## Interface
- `OP_W`, 24, operand width in bits (1..32)
- `RES_W`, 32, stored result width (≤32)
- `CNT_W`, 16, completed-operation counter width (≤32)
- `BASE_ADDR`, 16'h0380, register window base
- `clk` input 1 — single clock, all logic on rising edge
- `reset` input 1 — asynchronous, active-high; clears all state immediately
- `saddress` input 16 — register address
- `srd` input 1 — read strobe, sampled on `clk`
- `swr` input 1 — write strobe, sampled on `clk`
- `sdata_in` input 32 — write data
- `sdata_out` output 32 — registered read data
- `gpio_out` output 32 — zero-extended operation counter
- `irq` output 1 — one-cycle pulse on completion

## Operation
- Register map (offset from `BASE_ADDR`):
  - +0x00 A1 (RW, low OP_W bits)
  - +0x08 A2 (RW)
  - +0x10 W (RO, result)
  - +0x18 L (RO, ones count)
  - +0x20 CTRL/STATUS
- CTRL/STATUS fields:
  - write of any data starts an operation
  - read returns {29'b0, err, ready, valid}
- Operands are writable at any time. A1/A2 are snapshotted at start, so writes during an operation only affect the next one.
- States:
  - IDLE: wait for start.
  - MULT: OP_W cycles, one multiplier bit per cycle, 2·OP_W-bit accumulator.
  - COUNT: 1 cycle; L = popcount(W).
  - DONE: 1 cycle; counter += 1, `irq`=1, ready=1. Returns to IDLE.
- Accepted start in IDLE:
  - {ready,valid} := 2'b01
  - err := 0
  - go to MULT
- Start while not IDLE is ignored, and err := 1 (sticky until the next accepted start).
- Result and status:
  - W = product[RES_W-1:0]
  - valid = (product[2·OP_W-1:RES_W] == 0); always 1 if 2·OP_W ≤ RES_W
  - L is $clog2(RES_W+1) bits, zero-extended on read.
- Reads:
  - W and L read 0 while ready=0.
  - Unmapped addresses read 0.
  - `sdata_out` updates only on a cycle with `srd` sampled high; it holds otherwise.
- The counter wraps from all-ones to 0.
- `gpio_out` = {zero-extension, counter}.

## Timing
- Reset values:
  - `sdata_out`=0, `gpio_out`=0, `irq`=0
  - A1=A2=W=L=0, state IDLE
  - {err,ready,valid}=3'b011
- Start sampled at edge k:
  - MULT occupies edges k+1..k+OP_W.
  - COUNT at k+OP_W+1.
  - DONE at k+OP_W+2: `irq` high for that cycle; counter and status updated.
- A read sampled at edge k+OP_W+3 or later returns ready=1.
- Read data appears in `sdata_out` one edge after the `srd` sample.
- Simultaneous `srd` and `swr` to the same address: the write commits, and the read returns the pre-write value.
- Reset asserted mid-operation aborts it: no `irq`, no counter increment, all values return to reset values.

## Structure
- Package `gpio_mulcnt_pkg` holds:
  - state enum
  - register offset localparams
  - STATUS bit indices
- Sub-module `mul_seq_core`: the shift-add multiplier datapath. It takes OP_W-wide operands plus `load` and `step` controls, and outputs the 2·OP_W product.
- Top level holds the bus decode, FSM, popcount, counter and `irq`.

## Test plan
All scenarios use default parameters unless stated.
- A1=3, A2=5, start → after OP_W+3 cycles: W=0x0000000F, L=4, STATUS=3'b011, `gpio_out`=1, single `irq` pulse.
- A1=A2=0xFFFFFF, start → W=0xFE000001, L=8, STATUS=3'b010 (overflow).
- Start, second start at cycle 5 → second start ignored; first result correct; STATUS err=1; counter +1 only.
- Start, read W at cycle 3 → 0; read address BASE+0x40 → 0; W write attempt has no effect.
- Start, assert `reset` at cycle 10 → all outputs 0; STATUS=3'b011; no `irq`; counter 0.
- CNT_W=4: 16 back-to-back operations → `gpio_out` steps 1..15 then 0.
